// File: rtl/misr_compactor.sv
// misr_compactor: multiple-input signature register with a run controller.
// Each enabled cycle, IN_WIDTH response bits are folded into a SIG_WIDTH
// Galois-LFSR signature. A run lasts CYCLES enabled cycles. At the end of a
// run the signature is compared against the golden input.
// Optional build macro MISR_XMASK_EN: adds an xmask input. Masked bits are
// forced to zero before compaction, so X values from the CUT cannot reach
// the signature.
module misr_compactor #(
  parameter int                   SIG_WIDTH = 16,
  parameter int                   IN_WIDTH  = 10,
  parameter logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(16'h002D),
  parameter logic [SIG_WIDTH-1:0] SEED      = '0,
  parameter int                   CYCLES    = 256,
  localparam int                  CNT_W     = $clog2(CYCLES + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 enable,
  input  logic [IN_WIDTH-1:0]  data_in,
`ifdef MISR_XMASK_EN
  input  logic [IN_WIDTH-1:0]  xmask,
`endif
  input  logic [SIG_WIDTH-1:0] golden,
  output logic [SIG_WIDTH-1:0] signature,
  output logic [CNT_W-1:0]     cycle_count,
  output logic                 busy,
  output logic                 done,
  output logic                 pass_nfail
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(CYCLES - 1);
  localparam logic [CNT_W-1:0] CYC_MAX  = CNT_W'(CYCLES);

  state_t               state_q, state_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, done_q, pass_q, pass_d;
  logic [IN_WIDTH-1:0]  absorbed;
  logic [SIG_WIDTH-1:0] stepSig;

  // Response bits that actually enter the signature this cycle.
`ifdef MISR_XMASK_EN
  assign absorbed = data_in & ~xmask;
`else
  assign absorbed = data_in;
`endif

  // One MISR step: shift left, fold the MSB back through the taps,
  // then XOR in the zero-extended response bits.
  assign stepSig = {sig_q[SIG_WIDTH-2:0], 1'b0}
                 ^ (sig_q[SIG_WIDTH-1] ? POLY : '0)
                 ^ SIG_WIDTH'(absorbed);

  // Next-state logic for the run controller, signature and cycle counter.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sig_d   = SEED;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (enable) begin
          sig_d = stepSig;
          if (cnt_q != CYC_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (cnt_q == CYC_LAST) begin
            state_d = DONE;
            pass_d  = (stepSig == golden);
          end
        end
      end
      DONE: begin
        if (start) begin
          sig_d   = SEED;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          pass_d = (sig_q == golden);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs; busy/done decode the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
      pass_q  <= pass_d;
    end
  end

  assign signature   = sig_q;
  assign cycle_count = cnt_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass_nfail  = pass_q;

endmodule

// File: tb/tb_misr_compactor.sv
// tb_misr_compactor: directed bench for misr_compactor.
// Instance A (SEED=1, CYCLES=16) covers shifting, stalls, abort and
// start/abort priority. Instance B (SEED=0, CYCLES=1) covers data
// absorption, the verdict and the optional xmask (MISR_XMASK_EN).
module tb_misr_compactor;

  logic        clock = 1'b0;
  logic        reset_n;

  logic        startA, abortA, enableA;
  logic [9:0]  dataA, xmaskA;
  logic [15:0] goldenA, sigA;
  logic [4:0]  cntA;
  logic        busyA, doneA, passA;

  logic        startB, abortB, enableB;
  logic [9:0]  dataB, xmaskB;
  logic [15:0] goldenB, sigB;
  logic [0:0]  cntB;
  logic        busyB, doneB, passB;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  misr_compactor #(
    .SIG_WIDTH(16), .IN_WIDTH(10), .POLY(16'h002D), .SEED(16'h0001), .CYCLES(16)
  ) dutA (
    .clock(clock), .reset_n(reset_n), .start(startA), .abort(abortA),
    .enable(enableA), .data_in(dataA),
`ifdef MISR_XMASK_EN
    .xmask(xmaskA),
`endif
    .golden(goldenA), .signature(sigA), .cycle_count(cntA),
    .busy(busyA), .done(doneA), .pass_nfail(passA)
  );

  misr_compactor #(
    .SIG_WIDTH(16), .IN_WIDTH(10), .POLY(16'h002D), .SEED(16'h0000), .CYCLES(1)
  ) dutB (
    .clock(clock), .reset_n(reset_n), .start(startB), .abort(abortB),
    .enable(enableB), .data_in(dataB),
`ifdef MISR_XMASK_EN
    .xmask(xmaskB),
`endif
    .golden(goldenB), .signature(sigB), .cycle_count(cntB),
    .busy(busyB), .done(doneB), .pass_nfail(passB)
  );

  // Advance one rising edge and settle just after it.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      startA = 1'($urandom); abortA = 1'($urandom); enableA = 1'($urandom);
      dataA = 10'($urandom); goldenA = 16'($urandom); xmaskA = 10'($urandom);
      startB = 1'($urandom); abortB = 1'($urandom); enableB = 1'($urandom);
      dataB = 10'($urandom); goldenB = 16'($urandom); xmaskB = 10'($urandom);
      tick(1);
    end
    checks++;
    if ({sigA, cntA, busyA, doneA, passA} !== {16'h0001, 5'd0, 3'b000})
      $display("[TB] FAIL reset_A: got sig=%h cnt=%0d b/d/p=%b%b%b required sig=0001 cnt=0 b/d/p=000",
               sigA, cntA, busyA, doneA, passA);
    else passed++;
    checks++;
    if ({sigB, cntB, busyB, doneB, passB} !== {16'h0000, 1'd0, 3'b000})
      $display("[TB] FAIL reset_B: got sig=%h cnt=%0d b/d/p=%b%b%b required sig=0000 cnt=0 b/d/p=000",
               sigB, cntB, busyB, doneB, passB);
    else passed++;
    startA = 0; abortA = 0; enableA = 0; dataA = '0; goldenA = '0; xmaskA = '0;
    startB = 0; abortB = 0; enableB = 0; dataB = '0; goldenB = '0; xmaskB = '0;
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_shift;
    goldenA = 16'h002D;
    startA = 1; enableA = 1;
    tick(1);
    startA = 0;
    checks++;
    if ({sigA, cntA, busyA, doneA} !== {16'h0001, 5'd0, 2'b10})
      $display("[TB] FAIL shift_start: got sig=%h cnt=%0d b/d=%b%b required sig=0001 cnt=0 b/d=10",
               sigA, cntA, busyA, doneA);
    else passed++;
    tick(15);
    checks++;
    if ({sigA, cntA, busyA, doneA} !== {16'h8000, 5'd15, 2'b10})
      $display("[TB] FAIL shift_15: got sig=%h cnt=%0d b/d=%b%b required sig=8000 cnt=15 b/d=10",
               sigA, cntA, busyA, doneA);
    else passed++;
    tick(1);
    checks++;
    if ({sigA, cntA, busyA, doneA, passA} !== {16'h002D, 5'd16, 3'b011})
      $display("[TB] FAIL shift_done: got sig=%h cnt=%0d b/d/p=%b%b%b required sig=002d cnt=16 b/d/p=011",
               sigA, cntA, busyA, doneA, passA);
    else passed++;
    tick(2);
    checks++;
    if ({sigA, cntA, doneA, passA} !== {16'h002D, 5'd16, 2'b11})
      $display("[TB] FAIL shift_hold: got sig=%h cnt=%0d d/p=%b%b required sig=002d cnt=16 d/p=11",
               sigA, cntA, doneA, passA);
    else passed++;
  endtask

  task automatic test_absorb;
    startB = 1; enableB = 1; dataB = 10'h003; goldenB = 16'h0003;
    tick(1);
    startB = 0;
    checks++;
    if ({sigB, busyB, doneB} !== {16'h0000, 2'b10})
      $display("[TB] FAIL absorb_start: got sig=%h b/d=%b%b required sig=0000 b/d=10",
               sigB, busyB, doneB);
    else passed++;
    tick(1);
    checks++;
    if ({sigB, cntB, busyB, doneB, passB} !== {16'h0003, 1'd1, 3'b011})
      $display("[TB] FAIL absorb_done: got sig=%h cnt=%0d b/d/p=%b%b%b required sig=0003 cnt=1 b/d/p=011",
               sigB, cntB, busyB, doneB, passB);
    else passed++;
    goldenB = 16'h0004;
    tick(1);
    checks++;
    if ({sigB, doneB, passB} !== {16'h0003, 2'b10})
      $display("[TB] FAIL absorb_badgolden: got sig=%h d/p=%b%b required sig=0003 d/p=10",
               sigB, doneB, passB);
    else passed++;
    startB = 1; dataB = 10'h155;
    tick(1);
    startB = 0;
    checks++;
    if ({sigB, cntB, busyB, doneB, passB} !== {16'h0000, 1'd0, 3'b100})
      $display("[TB] FAIL absorb_restart: got sig=%h cnt=%0d b/d/p=%b%b%b required sig=0000 cnt=0 b/d/p=100",
               sigB, cntB, busyB, doneB, passB);
    else passed++;
    tick(1);
  endtask

  task automatic test_stall;
    startA = 1; enableA = 1;
    tick(1);
    startA = 0;
    tick(8);
    enableA = 0;
    tick(5);
    checks++;
    if ({sigA, cntA, busyA, doneA} !== {16'h0100, 5'd8, 2'b10})
      $display("[TB] FAIL stall_hold: got sig=%h cnt=%0d b/d=%b%b required sig=0100 cnt=8 b/d=10",
               sigA, cntA, busyA, doneA);
    else passed++;
    enableA = 1;
    tick(7);
    checks++;
    if ({cntA, doneA} !== {5'd15, 1'b0})
      $display("[TB] FAIL stall_late: got cnt=%0d done=%b required cnt=15 done=0", cntA, doneA);
    else passed++;
    tick(1);
    checks++;
    if ({sigA, cntA, busyA, doneA, passA} !== {16'h002D, 5'd16, 3'b011})
      $display("[TB] FAIL stall_done: got sig=%h cnt=%0d b/d/p=%b%b%b required sig=002d cnt=16 b/d/p=011",
               sigA, cntA, busyA, doneA, passA);
    else passed++;
  endtask

  task automatic test_abort;
    startA = 1; enableA = 1;
    tick(1);
    startA = 0;
    tick(3);
    startA = 1;
    tick(1);
    startA = 0;
    checks++;
    if ({sigA, cntA, busyA} !== {16'h0010, 5'd4, 1'b1})
      $display("[TB] FAIL start_in_run: got sig=%h cnt=%0d busy=%b required sig=0010 cnt=4 busy=1",
               sigA, cntA, busyA);
    else passed++;
    tick(3);
    abortA = 1;
    tick(1);
    checks++;
    if ({sigA, cntA, busyA, doneA, passA} !== {16'h0080, 5'd7, 3'b000})
      $display("[TB] FAIL abort_run: got sig=%h cnt=%0d b/d/p=%b%b%b required sig=0080 cnt=7 b/d/p=000",
               sigA, cntA, busyA, doneA, passA);
    else passed++;
    tick(1);
    checks++;
    if ({sigA, cntA, busyA} !== {16'h0080, 5'd7, 1'b0})
      $display("[TB] FAIL abort_idle: got sig=%h cnt=%0d busy=%b required sig=0080 cnt=7 busy=0",
               sigA, cntA, busyA);
    else passed++;
    startA = 1;
    tick(1);
    startA = 0;
    checks++;
    if ({sigA, cntA, busyA} !== {16'h0001, 5'd0, 1'b1})
      $display("[TB] FAIL start_beats_abort: got sig=%h cnt=%0d busy=%b required sig=0001 cnt=0 busy=1",
               sigA, cntA, busyA);
    else passed++;
    startA = 1;
    tick(1);
    startA = 0; abortA = 0;
    checks++;
    if ({sigA, cntA, busyA, doneA} !== {16'h0001, 5'd0, 2'b00})
      $display("[TB] FAIL abort_beats_start: got sig=%h cnt=%0d b/d=%b%b required sig=0001 cnt=0 b/d=00",
               sigA, cntA, busyA, doneA);
    else passed++;
  endtask

  task automatic test_xmask;
    logic [15:0] expSig;
`ifdef MISR_XMASK_EN
    expSig = 16'h0000;
`else
    expSig = 16'h03FF;
`endif
    startB = 1; enableB = 1; dataB = 10'h3FF; xmaskB = 10'h3FF; goldenB = 16'h0000;
    tick(1);
    startB = 0;
    tick(1);
    checks++;
    if ({sigB, doneB} !== {expSig, 1'b1})
      $display("[TB] FAIL xmask_full: got sig=%h done=%b required sig=%h done=1",
               sigB, doneB, expSig);
    else passed++;
    xmaskB = '0;
  endtask

  task automatic test_reset_midrun;
    startA = 1; enableA = 1;
    tick(1);
    startA = 0;
    tick(3);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({sigA, cntA, busyA, doneA, passA} !== {16'h0001, 5'd0, 3'b000})
      $display("[TB] FAIL reset_midrun: got sig=%h cnt=%0d b/d/p=%b%b%b required sig=0001 cnt=0 b/d/p=000",
               sigA, cntA, busyA, doneA, passA);
    else passed++;
    enableA = 0;
    reset_n = 1'b1;
    tick(1);
  endtask

  initial begin
    test_reset;
    test_shift;
    test_absorb;
    test_stall;
    test_abort;
    test_xmask;
    test_reset_midrun;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
